// File: rtl/common_dffram_2a1wbnr.sv
// ============================================================================
// common_dffram_2a1wbnr
// ----------------------------------------------------------------------------
// Flip-flop based RAM with one bit-masked write port and RAM_READ_PORTS
// independent read ports. Used for register files, predictor tables and tag
// arrays that need several reads per cycle.
//
// Every entry resets asynchronously to its slice of RAM_RESET_VALUE. A
// synchronous flash-clear (clr) restores the whole array to that image in one
// cycle, and it takes priority over a write in the same cycle.
//
// Read ports are either combinational (zero latency) or registered (1 cycle,
// gated by enb[k]). With RAM_BYPASS=1 a port sees the value the addressed
// entry will hold after the current edge (write-through / clear-through);
// with RAM_BYPASS=0 it sees the current contents (read-before-write).
//
// Ports:
//   clk     in   clock, all state updates on the rising edge
//   resetn  in   asynchronous reset, active-low
//   clr     in   synchronous flash-clear to RAM_RESET_VALUE
//   addra   in   write address
//   ena     in   write enable
//   wea     in   per-bit write mask
//   dina    in   write data
//   enb     in   per-read-port enable (registered read mode only)
//   addrb   in   packed read addresses, port k at [k*AW +: AW]
//   doutb   out  packed read data,      port k at [k*DW +: DW]
// ============================================================================
module common_dffram_2a1wbnr #(
    parameter int RAM_DATA_WIDTH      = 8,
    parameter int RAM_ADDR_WIDTH      = 2,
    parameter int RAM_READ_PORTS      = 2,
    parameter int RAM_READ_REGISTERED = 0,
    parameter int RAM_BYPASS          = 0,
    parameter logic [(2**RAM_ADDR_WIDTH)*RAM_DATA_WIDTH-1:0] RAM_RESET_VALUE = '0
) (
    input  logic                                     clk,
    input  logic                                     resetn,
    input  logic                                     clr,
    input  logic [RAM_ADDR_WIDTH-1:0]                addra,
    input  logic                                     ena,
    input  logic [RAM_DATA_WIDTH-1:0]                wea,
    input  logic [RAM_DATA_WIDTH-1:0]                dina,
    input  logic [RAM_READ_PORTS-1:0]                enb,
    input  logic [RAM_READ_PORTS*RAM_ADDR_WIDTH-1:0] addrb,
    output logic [RAM_READ_PORTS*RAM_DATA_WIDTH-1:0] doutb
);

    localparam int DW    = RAM_DATA_WIDTH;
    localparam int AW    = RAM_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] rst_ent [DEPTH];

    // Reset image unpacked once so both the array and the bypass path can
    // index it by address.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rst_ent
        assign rst_ent[i] = RAM_RESET_VALUE[i*DW +: DW];
    end

    // ------------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= rst_ent[i];
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= rst_ent[i];
            end
        end else if (ena) begin
            mem[addra] <= (mem[addra] & ~wea) | (dina & wea);
        end
    end

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < RAM_READ_PORTS; k++) begin : g_rd
        logic [AW-1:0] rd_addr;
        logic [DW-1:0] mem_rd;
        logic [DW-1:0] rd_sel;

        assign rd_addr = addrb[k*AW +: AW];
        assign mem_rd  = mem[rd_addr];

        if (RAM_BYPASS != 0) begin : g_byp
            logic hit;
            // Next value of the addressed entry: clear beats write, and a
            // write only affects the bits selected by wea.
            assign hit    = ena && (addra == rd_addr);
            assign rd_sel = clr ? rst_ent[rd_addr]
                          : hit ? ((mem_rd & ~wea) | (dina & wea))
                          : mem_rd;
        end else begin : g_nobyp
            assign rd_sel = mem_rd;
        end

        if (RAM_READ_REGISTERED != 0) begin : g_reg
            logic [DW-1:0] dout_q;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    dout_q <= '0;
                end else if (enb[k]) begin
                    dout_q <= rd_sel;
                end
            end

            assign doutb[k*DW +: DW] = dout_q;
        end else begin : g_comb
            assign doutb[k*DW +: DW] = rd_sel;
        end
    end

    // Combinational read ports have no use for the read enables.
    if (RAM_READ_REGISTERED == 0) begin : g_no_enb
        logic unused_enb;
        assign unused_enb = ^enb;
    end

endmodule

// File: tb/tb_common_dffram_2a1wbnr.sv
// ============================================================================
// tb_common_dffram_2a1wbnr
// ----------------------------------------------------------------------------
// Four instances share one stimulus stream, one per read-mode combination:
//   u_c0 : combinational, read-before-write
//   u_c1 : combinational, write-through
//   u_r0 : registered,    read-before-write
//   u_r1 : registered,    write-through
// Reset image 32'h44332211 -> entry0=11, entry1=22, entry2=33, entry3=44.
// Read port 0 occupies the low byte of doutb / low two bits of addrb.
// ============================================================================
module tb_common_dffram_2a1wbnr;

    localparam logic [31:0] RST_IMG = 32'h44332211;

    logic        clk;
    logic        clk_run;
    logic        resetn;
    logic        clr;
    logic [1:0]  addra;
    logic        ena;
    logic [7:0]  wea;
    logic [7:0]  dina;
    logic [1:0]  enb;
    logic [3:0]  addrb;
    logic [15:0] dout_c0, dout_c1, dout_r0, dout_r1;

    int checks;
    int failures;

    common_dffram_2a1wbnr #(
        .RAM_DATA_WIDTH(8), .RAM_ADDR_WIDTH(2), .RAM_READ_PORTS(2),
        .RAM_READ_REGISTERED(0), .RAM_BYPASS(0), .RAM_RESET_VALUE(RST_IMG)
    ) u_c0 (
        .clk(clk), .resetn(resetn), .clr(clr), .addra(addra), .ena(ena),
        .wea(wea), .dina(dina), .enb(enb), .addrb(addrb), .doutb(dout_c0)
    );

    common_dffram_2a1wbnr #(
        .RAM_DATA_WIDTH(8), .RAM_ADDR_WIDTH(2), .RAM_READ_PORTS(2),
        .RAM_READ_REGISTERED(0), .RAM_BYPASS(1), .RAM_RESET_VALUE(RST_IMG)
    ) u_c1 (
        .clk(clk), .resetn(resetn), .clr(clr), .addra(addra), .ena(ena),
        .wea(wea), .dina(dina), .enb(enb), .addrb(addrb), .doutb(dout_c1)
    );

    common_dffram_2a1wbnr #(
        .RAM_DATA_WIDTH(8), .RAM_ADDR_WIDTH(2), .RAM_READ_PORTS(2),
        .RAM_READ_REGISTERED(1), .RAM_BYPASS(0), .RAM_RESET_VALUE(RST_IMG)
    ) u_r0 (
        .clk(clk), .resetn(resetn), .clr(clr), .addra(addra), .ena(ena),
        .wea(wea), .dina(dina), .enb(enb), .addrb(addrb), .doutb(dout_r0)
    );

    common_dffram_2a1wbnr #(
        .RAM_DATA_WIDTH(8), .RAM_ADDR_WIDTH(2), .RAM_READ_PORTS(2),
        .RAM_READ_REGISTERED(1), .RAM_BYPASS(1), .RAM_RESET_VALUE(RST_IMG)
    ) u_r1 (
        .clk(clk), .resetn(resetn), .clr(clr), .addra(addra), .ena(ena),
        .wea(wea), .dina(dina), .enb(enb), .addrb(addrb), .doutb(dout_r1)
    );

    // Gated clock so the reset test can run with no edges at all.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic test_reset();
        clk_run = 1'b0;
        resetn  = 1'b1;
        clr = 1'b0; ena = 1'b0; addra = 2'd0; wea = 8'h00; dina = 8'h00;
        enb = 2'b00; addrb = {2'd3, 2'd2};
        #3;
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        #2;
        checks++;
        if (dout_c0 !== 16'h4433) begin
            failures++; $display("FAIL reset_comb_nobyp got=%h exp=%h", dout_c0, 16'h4433);
        end
        checks++;
        if (dout_c1 !== 16'h4433) begin
            failures++; $display("FAIL reset_comb_byp got=%h exp=%h", dout_c1, 16'h4433);
        end
        checks++;
        if (dout_r0 !== 16'h0000) begin
            failures++; $display("FAIL reset_reg_nobyp got=%h exp=%h", dout_r0, 16'h0000);
        end
        checks++;
        if (dout_r1 !== 16'h0000) begin
            failures++; $display("FAIL reset_reg_byp got=%h exp=%h", dout_r1, 16'h0000);
        end
        // Edges with enb=0 must leave registered outputs at zero.
        clk_run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dout_r0 !== 16'h0000) begin
            failures++; $display("FAIL reset_reg_hold got=%h exp=%h", dout_r0, 16'h0000);
        end
        @(negedge clk);
        enb = 2'b11;
        @(posedge clk); #1;
        checks++;
        if (dout_r0 !== 16'h4433) begin
            failures++; $display("FAIL reset_reg_first_enb got=%h exp=%h", dout_r0, 16'h4433);
        end
        checks++;
        if (dout_r1 !== 16'h4433) begin
            failures++; $display("FAIL reset_reg_byp_first_enb got=%h exp=%h", dout_r1, 16'h4433);
        end
    endtask

    task automatic test_bit_write();
        @(negedge clk);
        ena = 1'b1; addra = 2'd1; wea = 8'h0F; dina = 8'hAB;
        enb = 2'b01; addrb = {2'd0, 2'd1};
        #1;
        checks++;
        if (dout_c0[7:0] !== 8'h22) begin
            failures++; $display("FAIL bitwr_comb_pre got=%h exp=%h", dout_c0[7:0], 8'h22);
        end
        checks++;
        if (dout_c1[7:0] !== 8'h2B) begin
            failures++; $display("FAIL bitwr_comb_byp got=%h exp=%h", dout_c1[7:0], 8'h2B);
        end
        @(posedge clk); #1;
        checks++;
        if (dout_c0[7:0] !== 8'h2B) begin
            failures++; $display("FAIL bitwr_comb_post got=%h exp=%h", dout_c0[7:0], 8'h2B);
        end
        checks++;
        if (dout_r0[7:0] !== 8'h22) begin
            failures++; $display("FAIL bitwr_reg_nobyp got=%h exp=%h", dout_r0[7:0], 8'h22);
        end
        checks++;
        if (dout_r1[7:0] !== 8'h2B) begin
            failures++; $display("FAIL bitwr_reg_byp got=%h exp=%h", dout_r1[7:0], 8'h2B);
        end
        checks++;
        if (dout_r0[15:8] !== 8'h44) begin
            failures++; $display("FAIL bitwr_port1_hold got=%h exp=%h", dout_r0[15:8], 8'h44);
        end
        @(negedge clk);
        ena = 1'b0; enb = 2'b00;
    endtask

    task automatic test_collision();
        @(negedge clk);
        ena = 1'b1; addra = 2'd1; wea = 8'hFF; dina = 8'hFF;
        enb = 2'b01; addrb = {2'd0, 2'd1};
        #1;
        checks++;
        if (dout_c0[7:0] !== 8'h2B) begin
            failures++; $display("FAIL coll_comb_nobyp got=%h exp=%h", dout_c0[7:0], 8'h2B);
        end
        checks++;
        if (dout_c1[7:0] !== 8'hFF) begin
            failures++; $display("FAIL coll_comb_byp got=%h exp=%h", dout_c1[7:0], 8'hFF);
        end
        @(posedge clk); #1;
        checks++;
        if (dout_r0[7:0] !== 8'h2B) begin
            failures++; $display("FAIL coll_reg_nobyp got=%h exp=%h", dout_r0[7:0], 8'h2B);
        end
        checks++;
        if (dout_r1[7:0] !== 8'hFF) begin
            failures++; $display("FAIL coll_reg_byp got=%h exp=%h", dout_r1[7:0], 8'hFF);
        end
        @(negedge clk);
        ena = 1'b0; enb = 2'b00;
    endtask

    task automatic test_clr();
        @(negedge clk);
        clr = 1'b1; ena = 1'b1; addra = 2'd1; wea = 8'hFF; dina = 8'h5A;
        enb = 2'b11; addrb = {2'd0, 2'd1};
        #1;
        checks++;
        if (dout_c0 !== 16'h11FF) begin
            failures++; $display("FAIL clr_comb_pre got=%h exp=%h", dout_c0, 16'h11FF);
        end
        checks++;
        if (dout_c1 !== 16'h1122) begin
            failures++; $display("FAIL clr_comb_byp got=%h exp=%h", dout_c1, 16'h1122);
        end
        @(posedge clk); #1;
        checks++;
        if (dout_c0 !== 16'h1122) begin
            failures++; $display("FAIL clr_comb_post got=%h exp=%h", dout_c0, 16'h1122);
        end
        checks++;
        if (dout_r0 !== 16'h11FF) begin
            failures++; $display("FAIL clr_reg_nobyp got=%h exp=%h", dout_r0, 16'h11FF);
        end
        checks++;
        if (dout_r1 !== 16'h1122) begin
            failures++; $display("FAIL clr_reg_byp got=%h exp=%h", dout_r1, 16'h1122);
        end
        @(negedge clk);
        clr = 1'b0; ena = 1'b0; enb = 2'b00; addrb = {2'd3, 2'd2};
        #1;
        checks++;
        if (dout_c0 !== 16'h4433) begin
            failures++; $display("FAIL clr_upper_entries got=%h exp=%h", dout_c0, 16'h4433);
        end
    endtask

    task automatic test_enable_hold();
        logic [15:0] r0_before;
        logic [15:0] r1_before;
        r0_before = 16'h11FF;
        r1_before = 16'h1122;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            enb = 2'b00; ena = 1'b1; addra = 2'd2; wea = 8'hFF;
            dina = 8'h60 + 8'(i);
            addrb = (i % 2 == 0) ? {2'd2, 2'd3} : {2'd1, 2'd0};
            @(posedge clk); #1;
            checks++;
            if (dout_r0 !== r0_before) begin
                failures++; $display("FAIL hold_reg_nobyp[%0d] got=%h exp=%h", i, dout_r0, r0_before);
            end
            checks++;
            if (dout_r1 !== r1_before) begin
                failures++; $display("FAIL hold_reg_byp[%0d] got=%h exp=%h", i, dout_r1, r1_before);
            end
        end
        @(negedge clk);
        ena = 1'b0; enb = 2'b11; addrb = {2'd2, 2'd1};
        @(posedge clk); #1;
        checks++;
        if (dout_r0 !== 16'h6222) begin
            failures++; $display("FAIL hold_release_nobyp got=%h exp=%h", dout_r0, 16'h6222);
        end
        checks++;
        if (dout_r1 !== 16'h6222) begin
            failures++; $display("FAIL hold_release_byp got=%h exp=%h", dout_r1, 16'h6222);
        end
        checks++;
        if (dout_c0 !== 16'h6222) begin
            failures++; $display("FAIL hold_comb_contents got=%h exp=%h", dout_c0, 16'h6222);
        end
        @(negedge clk);
        enb = 2'b00;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        ena = 1'b1; addra = 2'd0; wea = 8'hFF; dina = 8'hA0; enb = 2'b00;
        addrb = {2'd3, 2'd0};
        @(negedge clk);
        addra = 2'd3; dina = 8'hB3;
        @(negedge clk);
        checks++;
        if (dout_c0 !== 16'hB3A0) begin
            failures++; $display("FAIL b2b_writes got=%h exp=%h", dout_c0, 16'hB3A0);
        end
        addra = 2'd2; dina = 8'hC2;
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (dout_c0 !== 16'h4411) begin
            failures++; $display("FAIL b2b_midreset_comb got=%h exp=%h", dout_c0, 16'h4411);
        end
        checks++;
        if (dout_r1 !== 16'h0000) begin
            failures++; $display("FAIL b2b_midreset_reg got=%h exp=%h", dout_r1, 16'h0000);
        end
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        addrb = {2'd2, 2'd0};
        #1;
        checks++;
        if (dout_c0 !== 16'hC211) begin
            failures++; $display("FAIL b2b_first_write_after_reset got=%h exp=%h", dout_c0, 16'hC211);
        end
        checks++;
        if (dout_r0 !== 16'h0000) begin
            failures++; $display("FAIL b2b_reg_after_reset got=%h exp=%h", dout_r0, 16'h0000);
        end
        @(negedge clk);
        ena = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk_run  = 1'b0;
        resetn   = 1'b1;
        test_reset();
        test_bit_write();
        test_collision();
        test_clr();
        test_enable_hold();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/common_dffram_2a1wbnr.md
Name: common_dffram_2a1wbnr

Overview:
Parametrised DFF-based RAM with a single bit-masked write port and N independent read ports. Each read port is either combinational or registered, with an optional write-to-read bypass. Also provides a synchronous flash-clear that restores every entry to its reset image in one cycle. Serves register files, predictor tables and tag arrays in the core that need several reads per cycle.

Parameters:
RAM_DATA_WIDTH, 8, bits per entry (>=1)
RAM_ADDR_WIDTH, 2, address bits; depth DEPTH = 2^RAM_ADDR_WIDTH (>=1)
RAM_READ_PORTS, 2, number of read ports NR (>=1)
RAM_READ_REGISTERED, 0, 0 = combinational read; 1 = read data registered, 1-cycle latency
RAM_BYPASS, 0, 1 = same-cycle write data forwarded to matching read ports; 0 = read-before-write
RAM_RESET_VALUE, all zeros, DEPTH*RAM_DATA_WIDTH-bit image; entry i = bits [i*RAM_DATA_WIDTH +: RAM_DATA_WIDTH]

Ports:
clk  in  1  clock; all state updates on the rising edge
resetn  in  1  asynchronous reset, active-low
clr  in  1  synchronous flash-clear of all entries to RAM_RESET_VALUE
addra  in  RAM_ADDR_WIDTH  write address
ena  in  1  write port enable
wea  in  RAM_DATA_WIDTH  per-bit write enable
dina  in  RAM_DATA_WIDTH  write data
enb  in  NR  per-read-port enable; used only when RAM_READ_REGISTERED=1
addrb  in  NR*RAM_ADDR_WIDTH  packed read addresses; port k = [k*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH]
doutb  out  NR*RAM_DATA_WIDTH  packed read data; port k = [k*RAM_DATA_WIDTH +: RAM_DATA_WIDTH]

Behaviour:
- Reset: resetn low immediately forces every entry to its RAM_RESET_VALUE slice, without a clock edge. Registered read outputs reset to 0. Combinational outputs reflect the reset image immediately. Reset overrides clr and write.
- Write: on a clk edge with ena=1 and clr=0, each bit j of entry addra loads dina[j] where wea[j]=1; bits with wea[j]=0 hold. ena=0 or wea=0 leaves the array unchanged.
- clr: on a clk edge with clr=1, all entries load the reset image. A write in the same cycle is discarded (clr wins).
- Next-value function for read port k, nv(k):
  - clr=1 -> reset slice of entry addrb[k].
  - else, if ena=1 and addra==addrb[k] -> (mem & ~wea) | (dina & wea) of that entry.
  - else mem[addrb[k]].
- RAM_READ_REGISTERED=0:
  - RAM_BYPASS=0: doutb[k] = mem[addrb[k]], current contents, zero latency.
  - RAM_BYPASS=1: doutb[k] = nv(k), combinational write-through.
  - enb is ignored.
- RAM_READ_REGISTERED=1:
  - On a clk edge with enb[k]=1, port k's register loads nv(k) when RAM_BYPASS=1, or mem[addrb[k]] (pre-write value) when RAM_BYPASS=0.
  - enb[k]=0 holds the register.
  - Latency is 1 cycle.
- Ports are fully independent. Any number of ports may read the same address, including addra, in the same cycle.
- Address wrap is not possible: every addra/addrb value is a valid entry.
- No X propagation: an unwritten entry reads its reset slice.

Test Plan:
(DATA=8, ADDR=2, NR=2, RAM_RESET_VALUE=32'h44332211 unless stated)
1. Async reset: pulse resetn low with clk stopped; comb mode, addrb={2'd3,2'd2} -> doutb=16'h4433; registered mode -> doutb=16'h0000 until the first enb edge.
2. Bit write: ena=1, addra=1, wea=8'h0F, dina=8'hAB for one edge -> entry1=8'h2B; port0 at addr1 reads 8'h2B.
3. Registered collision: entry1=8'h2B, write addra=1, wea=8'hFF, dina=8'hFF, enb=2'b01, addrb0=1 -> BYPASS=0 next-cycle doutb0=8'h2B; BYPASS=1 doutb0=8'hFF. In comb BYPASS=1, 8'hFF appears in the same cycle.
4. clr vs write: entry1 previously 8'hFF; clr=1 together with ena=1, addra=1, dina=8'h5A, wea=8'hFF -> all entries restored, entry1=8'h22, 8'h5A never visible.
5. Enable hold: registered mode, enb=2'b00 for 3 edges while addrb and writes toggle -> doutb is unchanged. enb=2'b11 -> both ports update on the next edge with independent values.
6. Mid-operation reset: resetn falls between edges during back-to-back writes -> contents equal the reset image at once; after resetn rises, the first write lands correctly.
